instr_cache_refill: RTL and testbench
=====================================

// Module: instr_cache_refill
// PURPOSE
// - Line-refill engine directly downstream of instr_cache_ctlr.
// - Consumes instr_miss_f / instr_cache_rep_active from the controller and fetches the missing block from memory.
// - Memory side: single-request burst. Cache side: one word per write, then a line-complete pulse so the selected
//   way updates its tag/valid.
// - Drives the fetch-stage stall while a miss is outstanding.
// PARAMETERS
// - ADDR_W       32  fetch/memory address width
// - WORD_W       32  instruction word / memory beat width
// - BLOCK_WORDS  16  words per cache line; power of 2, >=2 (64 B line at defaults)
// PORTS
// - clk_i                     in   1                     clock, rising edge
// - reset_n_i                 in   1                     asynchronous, active-low reset
// - instr_miss_f_i            in   1                     fetch miss from instr_cache_ctlr
// - instr_cache_rep_active_i  in   1                     refill permitted (low during unresolved branch)
// - pc_f_i                    in   ADDR_W                fetch PC of the missing instruction
// - abort_i                   in   1                     redirect; drop a not-yet-accepted request
// - mem_req_o                 out  1                     burst read request
// - mem_addr_o                out  ADDR_W                line-aligned burst address
// - mem_ack_i                 in   1                     request accepted by memory
// - mem_rvalid_i              in   1                     read beat valid
// - mem_rdata_i               in   WORD_W                read beat data
// - fill_we_o                 out  1                     write one word into the cache line
// - fill_offset_o             out  $clog2(BLOCK_WORDS)   word index within the line
// - fill_data_o               out  WORD_W                word to write
// - line_done_o               out  1                     one-cycle pulse: line complete, set tag/valid
// - fill_addr_o               out  ADDR_W                line address of the line being filled
// - stall_f_o                 out  1                     fetch stall
// BEHAVIOUR
// - OFF_W = $clog2(BLOCK_WORDS*WORD_W/8).
// - Line address = {pc_f_i[ADDR_W-1:OFF_W], OFF_W'b0}.
// - States: IDLE, REQ, FILL, DONE. Reset state is IDLE.
// - Reset (asynchronous, any state, mid-burst included):
//   - state=IDLE, beat count=0, line address register=0.
//   - mem_req_o, fill_we_o, line_done_o = 0.
//   - mem_addr_o, fill_addr_o, fill_offset_o, fill_data_o = 0.
// - IDLE:
//   - instr_miss_f_i && instr_cache_rep_active_i -> latch line address, go to REQ.
//   - Miss with rep_active low -> stay in IDLE (deferred, no request).
// - REQ:
//   - mem_req_o=1, mem_addr_o=line address; both held stable until ack.
//   - mem_ack_i -> FILL with count=0.
//   - abort_i && !mem_ack_i -> IDLE. Ack in the same cycle as abort wins: go to FILL.
// - FILL:
//   - Each cycle with mem_rvalid_i: fill_we_o=1 combinationally.
//   - Same cycle: fill_offset_o=count, fill_data_o=mem_rdata_i; count increments at the clock edge.
//   - Gaps in rvalid are allowed; nothing is written in gap cycles.
//   - abort_i ignored: the in-flight burst always completes, and the line remains valid for its address.
//   - Beat with count==BLOCK_WORDS-1 -> DONE.
// - DONE: line_done_o=1 and fill_addr_o=line address for exactly one cycle, then IDLE.
// - fill_addr_o: driven with the line address in REQ, FILL and DONE; 0 in IDLE.
// - mem_rvalid_i outside FILL is ignored: no fill_we_o, count unchanged.
// - stall_f_o = (state!=IDLE) | instr_miss_f_i, combinational.
//   - A stall follows a miss in the same cycle; it is 1 in reset only if the miss input is high.
// - Latency:
//   - Miss to mem_req_o: 1 cycle.
//   - Last beat to line_done_o: 1 cycle.
//   - line_done_o to a new request: at least 2 cycles (IDLE re-evaluates the miss).
// - Count width is $clog2(BLOCK_WORDS); it returns to 0 on entering FILL and never wraps within a burst.
// TESTING
// 1. Reset: reset_n_i=0 mid-cycle -> all outputs 0 immediately; stall_f_o follows instr_miss_f_i.
// 2. Miss, pc_f_i=0x0000_1234, rep_active=1:
//    - Next cycle: mem_req_o=1, mem_addr_o=0x0000_1200.
//    - Ack after 3 cycles, then 16 beats of 0xA000_0000+i with 2 idle gaps -> fill_we_o on each beat,
//      fill_offset_o=i, fill_data_o=0xA000_0000+i.
//    - Then line_done_o pulses once with fill_addr_o=0x1200.
// 3. Miss with rep_active=0 for 4 cycles -> mem_req_o stays 0, stall_f_o=1.
//    - rep_active rises -> mem_req_o=1 on the next cycle.
// 4. abort_i in REQ, no ack -> IDLE next cycle, mem_req_o=0.
//    - abort_i and mem_ack_i together -> FILL, and the burst completes normally.
// 5. reset_n_i pulsed after beat 7 of a burst -> IDLE, fill_we_o=0, and the remaining beats are ignored.
//    - The next miss starts at fill_offset_o=0.
// 6. mem_rvalid_i=1 in IDLE and in REQ -> fill_we_o stays 0; line_done_o never asserts.

Source files
------------

// File: rtl/instr_cache_refill.sv
// Line-refill engine: fetches a missing instruction-cache line as one memory burst
// and streams it into the selected way one word per beat, stalling fetch meanwhile.
module instr_cache_refill #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           instr_miss_f_i,
    input  logic                           instr_cache_rep_active_i,
    input  logic [ADDR_W-1:0]              pc_f_i,
    input  logic                           abort_i,
    output logic                           mem_req_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    input  logic                           mem_ack_i,
    input  logic                           mem_rvalid_i,
    input  logic [WORD_W-1:0]              mem_rdata_i,
    output logic                           fill_we_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_offset_o,
    output logic [WORD_W-1:0]              fill_data_o,
    output logic                           line_done_o,
    output logic [ADDR_W-1:0]              fill_addr_o,
    output logic                           stall_f_o
);

    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS * WORD_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'(1) << OFF_W) - 64'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   line_q,  line_d;

    // State, beat counter and latched line address.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            line_q  <= line_d;
        end
    end

    // Next-state and output decode; outputs follow the state (and beat inputs in FILL).
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        line_d        = line_q;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        fill_we_o     = 1'b0;
        fill_offset_o = '0;
        fill_data_o   = '0;
        line_done_o   = 1'b0;
        fill_addr_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (instr_miss_f_i && instr_cache_rep_active_i) begin
                    line_d  = pc_f_i & ~OFF_MASK;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = line_q;
                fill_addr_o = line_q;
                // Acceptance wins over a simultaneous redirect: the burst is committed.
                if (mem_ack_i) begin
                    count_d = '0;
                    state_d = FILL;
                end else if (abort_i) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                fill_addr_o = line_q;
                if (mem_rvalid_i) begin
                    fill_we_o     = 1'b1;
                    fill_offset_o = count_q;
                    fill_data_o   = mem_rdata_i;
                    if (count_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                line_done_o = 1'b1;
                fill_addr_o = line_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch stall rises in the same cycle as the miss.
    assign stall_f_o = (state_q != IDLE) | instr_miss_f_i;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed + randomized bench for instr_cache_refill against a line-level reference model.
module tb_instr_cache_refill;

    logic        clk;
    logic        reset_n;
    logic        miss;
    logic        rep_active;
    logic [31:0] pc;
    logic        abort;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fill_we;
    logic [3:0]  fill_offset;
    logic [31:0] fill_data;
    logic        line_done;
    logic [31:0] fill_addr;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    instr_cache_refill #(
        .ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(16)
    ) dut (
        .clk_i                    (clk),
        .reset_n_i                (reset_n),
        .instr_miss_f_i           (miss),
        .instr_cache_rep_active_i (rep_active),
        .pc_f_i                   (pc),
        .abort_i                  (abort),
        .mem_req_o                (mem_req),
        .mem_addr_o               (mem_addr),
        .mem_ack_i                (mem_ack),
        .mem_rvalid_i             (mem_rvalid),
        .mem_rdata_i              (mem_rdata),
        .fill_we_o                (fill_we),
        .fill_offset_o            (fill_offset),
        .fill_data_o              (fill_data),
        .line_done_o              (line_done),
        .fill_addr_o              (fill_addr),
        .stall_f_o                (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete miss-to-line_done transaction, checked against the line-level model.
    task automatic run_miss(input logic [31:0] pc_v, input int defer, input int ack_dly,
                            input bit ab_ack, input int gap_pct, input bit seq_data,
                            input int g1, input int g2);
        logic [31:0] line;
        logic [31:0] data;
        bit          v;
        bit          gd1;
        bit          gd2;
        int          i;
        int          cycles;
        line   = (pc_v / 32'd64) * 32'd64;
        gd1    = 1'b0;
        gd2    = 1'b0;
        i      = 0;
        cycles = 0;
        pc     = pc_v;
        miss   = 1'b1;
        for (int d = 0; d < defer; d++) begin
            rep_active = 1'b0;
            #4;
            chk("defer_req", mem_req, 0);
            chk("defer_stall", stall, 1);
            cyc();
        end
        rep_active = 1'b1;
        #4;
        chk("miss_req_same_cycle", mem_req, 0);
        chk("miss_stall", stall, 1);
        cyc();
        miss = 1'b0;
        for (int k = 0; k < ack_dly; k++) begin
            mem_ack    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            #4;
            chk("req_valid", mem_req, 1);
            chk("req_addr", mem_addr, line);
            chk("req_fill_addr", fill_addr, line);
            chk("req_no_we", fill_we, 0);
            chk("req_no_done", line_done, 0);
            chk("req_stall", stall, 1);
            cyc();
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        abort      = ab_ack;
        #4;
        chk("ack_req", mem_req, 1);
        chk("ack_addr", mem_addr, line);
        cyc();
        mem_ack = 1'b0;
        abort   = 1'b0;
        while (i < 16) begin
            v = 1'b1;
            if (i == g1 && !gd1) begin
                v = 1'b0; gd1 = 1'b1;
            end else if (i == g2 && !gd2) begin
                v = 1'b0; gd2 = 1'b1;
            end else if (cycles < 64 && $urandom_range(0, 99) < gap_pct) begin
                v = 1'b0;
            end
            data       = seq_data ? (32'hA000_0000 + 32'(i)) : $urandom;
            mem_rvalid = v;
            mem_rdata  = data;
            abort      = ($urandom_range(0, 3) == 0);
            #4;
            chk("fill_we", fill_we, v);
            if (v) begin
                chk("fill_offset", fill_offset, i);
                chk("fill_data", fill_data, data);
            end
            chk("fill_no_done", line_done, 0);
            chk("fill_no_req", mem_req, 0);
            chk("fill_addr", fill_addr, line);
            chk("fill_stall", stall, 1);
            cyc();
            if (v) i++;
            cycles++;
        end
        mem_rvalid = 1'b0;
        abort      = 1'b0;
        #4;
        chk("done_pulse", line_done, 1);
        chk("done_fill_addr", fill_addr, line);
        chk("done_no_we", fill_we, 0);
        chk("done_stall", stall, 1);
        cyc();
        #4;
        chk("done_single", line_done, 0);
        chk("idle_fill_addr", fill_addr, 0);
        chk("idle_stall", stall, 0);
        chk("idle_req", mem_req, 0);
        cyc();
    endtask

    initial begin
        reset_n    = 1'b0;
        miss       = 1'b0;
        rep_active = 1'b0;
        pc         = '0;
        abort      = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset values, stall tracks the miss input during reset.
        #3;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", fill_we, 0);
        chk("rst_done", line_done, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_stall_lo", stall, 0);
        miss = 1'b1;
        #1;
        chk("rst_stall_hi", stall, 1);
        miss = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        // rvalid while idle is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #4;
        chk("idle_rvalid_we", fill_we, 0);
        chk("idle_rvalid_done", line_done, 0);
        cyc();
        mem_rvalid = 1'b0;

        // Directed miss at 0x1234: ack after 3 cycles, 16 sequential beats, 2 gaps.
        run_miss(32'h0000_1234, 0, 3, 1'b0, 0, 1'b1, 5, 11);

        // Deferred miss: rep_active low for 4 cycles.
        run_miss(32'h0000_8F7C, 4, 1, 1'b0, 0, 1'b1, -1, -1);

        // Abort in REQ without ack returns to idle.
        pc = 32'h0004_0088; miss = 1'b1; rep_active = 1'b1;
        cyc();
        miss  = 1'b0;
        abort = 1'b1;
        #4;
        chk("abort_req_before", mem_req, 1);
        cyc();
        abort = 1'b0;
        #4;
        chk("abort_req_after", mem_req, 0);
        chk("abort_stall", stall, 0);
        chk("abort_fill_addr", fill_addr, 0);
        cyc();

        // Abort together with ack: burst proceeds.
        run_miss(32'h0004_00C4, 0, 2, 1'b1, 20, 1'b0, -1, -1);

        // Reset mid-burst after beat 7; remaining beats must be ignored.
        pc = 32'h0000_2040; miss = 1'b1; rep_active = 1'b1;
        cyc();
        miss    = 1'b0;
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB000_0000 + 32'(b);
            #4;
            chk("pre_rst_offset", fill_offset, b);
            cyc();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hB000_0008;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_we", fill_we, 0);
        chk("midrst_offset", fill_offset, 0);
        chk("midrst_data", fill_data, 0);
        chk("midrst_req", mem_req, 0);
        chk("midrst_fill_addr", fill_addr, 0);
        chk("midrst_stall", stall, 0);
        #1;
        reset_n = 1'b1;
        cyc();
        for (int b = 8; b < 16; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB000_0000 + 32'(b);
            #4;
            chk("post_rst_we", fill_we, 0);
            chk("post_rst_done", line_done, 0);
            cyc();
        end
        mem_rvalid = 1'b0;
        run_miss(32'h0000_3000, 0, 0, 1'b0, 0, 1'b0, -1, -1);

        // Randomized transactions.
        for (int r = 0; r < 8; r++) begin
            run_miss($urandom, $urandom_range(0, 2), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), 30, 1'b0, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
